instruction_fetch: RTL and testbench

Multi-cycle instruction fetch unit for the non-pipelined MIPS core, directly upstream of the main control decoder. It holds the program counter, requests one instruction word at a time from instruction memory over a ready handshake, and presents the latched word (with its 6-bit opcode field) to control and the datapath. It then computes the next PC from the branch and jump outcomes returned by the datapath.

---
 rtl/mips_pkg.sv | 19 +
 rtl/next_pc.sv | 28 ++
 rtl/instruction_fetch.sv | 89 ++++++++
 tb/tb_instruction_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and instruction-field constants for the non-pipelined MIPS core.
// Used by the fetch unit and its next-PC helper.
package mips_pkg;

  localparam int INSTR_W         = 32;
  localparam int OPCODE_MSB      = 31;
  localparam int OPCODE_LSB      = 26;
  localparam int OPCODE_W        = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int JUMP_TARGET_MSB = 25;
  localparam int JUMP_TARGET_LSB = 0;
  localparam int JUMP_TARGET_W   = JUMP_TARGET_MSB - JUMP_TARGET_LSB + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    EXECUTE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection: sequential, taken branch or jump.
// Jump wins over a taken branch. All arithmetic wraps modulo 2^32.
module next_pc
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0]       pc,
  input  logic [INSTR_W-1:0]       branchOffset,
  input  logic [JUMP_TARGET_W-1:0] jumpTarget,
  input  logic                     branch,
  input  logic                     zero,
  input  logic                     jump,
  output logic [INSTR_W-1:0]       pcPlus4,
  output logic [INSTR_W-1:0]       nextPc
);

  assign pcPlus4 = pc + 32'd4;

  always_comb begin
    nextPc = pcPlus4;
    if (jump) begin
      nextPc = {pcPlus4[31:28], jumpTarget, 2'b00};
    end else if (branch && zero) begin
      // Offset is in words; the shift drops its top two bits, matching 32-bit wrap.
      nextPc = pcPlus4 + (branchOffset << 2);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Multi-cycle fetch unit: holds the PC, fetches one word per instruction and
// presents it to control/datapath, then advances the PC from branch/jump outcomes.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clock_in,
  input  logic                reset_in,
  output logic                imemReq_out,
  output logic [INSTR_W-1:0]  imemAddr_out,
  input  logic                imemReady_in,
  input  logic [INSTR_W-1:0]  imemData_in,
  input  logic                stall_in,
  input  logic                branch_in,
  input  logic                zero_in,
  input  logic                jump_in,
  input  logic [INSTR_W-1:0]  branchOffset_in,
  output logic [INSTR_W-1:0]  instruction_out,
  output logic [OPCODE_W-1:0] opcode_out,
  output logic [INSTR_W-1:0]  pcPlus4_out,
  output logic                valid_out,
  output fetch_state_t        state_out
);

  // Memory handshake: in FETCH imemReq_out is held high with imemAddr_out=PC;
  // the word is taken on the first rising edge where imemReady_in=1 (possibly
  // the first FETCH cycle). imemReady_in is ignored in every other state.
  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] pc_plus4;
  logic [INSTR_W-1:0] pc_next;

  next_pc u_next_pc (
    .pc           (pc_q),
    .branchOffset (branchOffset_in),
    .jumpTarget   (instr_q[JUMP_TARGET_MSB:JUMP_TARGET_LSB]),
    .branch       (branch_in),
    .zero         (zero_in),
    .jump         (jump_in),
    .pcPlus4      (pc_plus4),
    .nextPc       (pc_next)
  );

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imemReady_in) state_d = EXECUTE;
      EXECUTE: if (!stall_in) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imemReq_out = (state_q == FETCH);
    valid_out   = (state_q == EXECUTE) && !stall_in;
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (state_q == FETCH && imemReady_in) begin
        instr_q <= imemData_in;
      end
      if (state_q == EXECUTE && !stall_in) begin
        pc_q <= pc_next;
      end
    end
  end

  assign imemAddr_out    = pc_q;
  assign instruction_out = instr_q;
  assign opcode_out      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign pcPlus4_out     = pc_plus4;
  assign state_out       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed table of next-PC cases, hand-written
// latency/stall/reset sequences and randomized instructions against a PC model.
module tb_instruction_fetch;
  import mips_pkg::*;

  logic         clock_in = 1'b0;
  logic         reset_in;
  logic         imemReq_out;
  logic [31:0]  imemAddr_out;
  logic         imemReady_in;
  logic [31:0]  imemData_in;
  logic         stall_in;
  logic         branch_in;
  logic         zero_in;
  logic         jump_in;
  logic [31:0]  branchOffset_in;
  logic [31:0]  instruction_out;
  logic [5:0]   opcode_out;
  logic [31:0]  pcPlus4_out;
  logic         valid_out;
  fetch_state_t state_out;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clock_in        (clock_in),
    .reset_in        (reset_in),
    .imemReq_out     (imemReq_out),
    .imemAddr_out    (imemAddr_out),
    .imemReady_in    (imemReady_in),
    .imemData_in     (imemData_in),
    .stall_in        (stall_in),
    .branch_in       (branch_in),
    .zero_in         (zero_in),
    .jump_in         (jump_in),
    .branchOffset_in (branchOffset_in),
    .instruction_out (instruction_out),
    .opcode_out      (opcode_out),
    .pcPlus4_out     (pcPlus4_out),
    .valid_out       (valid_out),
    .state_out       (state_out)
  );

  // Clock / watchdog
  always #5 clock_in = ~clock_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] model_pc;

  typedef struct packed {
    logic [31:0] pre_pc;
    logic [31:0] instr;
    logic        br;
    logic        z;
    logic        j;
    logic [31:0] off;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC, written straight from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                           input logic br, input logic z, input logic j,
                                           input logic [31:0] off);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
    if (br && z) return seq + off * 4;
    return seq;
  endfunction

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // Driver: one full instruction (FETCH with waits, EXECUTE with stalls, release).
  task automatic do_instr(input logic [31:0] instr, input int waits, input int stalls,
                          input logic br, input logic z, input logic j, input logic [31:0] off);
    logic [31:0] junk;
    check("fetch_state", 32'(state_out), 32'(FETCH));
    check("fetch_req", 32'(imemReq_out), 32'd1);
    check("fetch_addr", imemAddr_out, model_pc);
    check("fetch_valid", 32'(valid_out), 32'd0);
    check("pc_plus4", pcPlus4_out, model_pc + 32'd4);
    for (int w = 0; w < waits; w++) begin
      imemReady_in = 1'b0;
      imemData_in  = $urandom;
      step();
      check("wait_state", 32'(state_out), 32'(FETCH));
      check("wait_addr", imemAddr_out, model_pc);
    end
    imemReady_in = 1'b1;
    imemData_in  = instr;
    step();
    imemReady_in = 1'b0;
    imemData_in  = $urandom;
    check("exec_state", 32'(state_out), 32'(EXECUTE));
    check("exec_instr", instruction_out, instr);
    check("exec_opcode", 32'(opcode_out), instr >> 26);
    check("exec_req", 32'(imemReq_out), 32'd0);
    for (int s = 0; s < stalls; s++) begin
      stall_in = 1'b1;
      junk = ~instr;
      imemReady_in = 1'b1;
      imemData_in  = junk;
      #1;
      check("stall_valid", 32'(valid_out), 32'd0);
      step();
      imemReady_in = 1'b0;
      check("stall_state", 32'(state_out), 32'(EXECUTE));
      check("stall_instr", instruction_out, instr);
      check("stall_pc", imemAddr_out, model_pc);
    end
    stall_in        = 1'b0;
    branch_in       = br;
    zero_in         = z;
    jump_in         = j;
    branchOffset_in = off;
    #1;
    check("release_valid", 32'(valid_out), 32'd1);
    step();
    branch_in       = 1'b0;
    zero_in         = 1'b0;
    jump_in         = 1'b0;
    branchOffset_in = $urandom;
    model_pc = ref_next(model_pc, instr, br, z, j, off);
  endtask

  // Steer the PC to a word-aligned target with a taken branch.
  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] d;
    d = target - (model_pc + 32'd4);
    do_instr(32'h0000_0000, 0, 0, 1'b1, 1'b1, 1'b0, d >> 2);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_000C};
    vecs[1] = '{32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0014};
    vecs[2] = '{32'h1000_0000, 32'h0800_0040, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h1000_0100};
    vecs[3] = '{32'h1000_0000, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h0000_0005, 32'h1000_0100};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};

    // Reset
    reset_in        = 1'b0;
    imemReady_in    = 1'b0;
    imemData_in     = 32'h0;
    stall_in        = 1'b0;
    branch_in       = 1'b0;
    zero_in         = 1'b0;
    jump_in         = 1'b0;
    branchOffset_in = 32'h0;
    #2;
    check("rst_state", 32'(state_out), 32'(IDLE));
    check("rst_req", 32'(imemReq_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_instr", instruction_out, 32'h0);
    check("rst_opcode", 32'(opcode_out), 32'h0);
    check("rst_addr", imemAddr_out, 32'h0);
    check("rst_pc_plus4", pcPlus4_out, 32'h4);
    step();
    reset_in = 1'b1;
    check("idle_after_release", 32'(state_out), 32'(IDLE));
    step();
    model_pc = 32'h0;

    // Zero-wait fetch of an lw
    do_instr(32'h8C08_0004, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("lw_next_addr", imemAddr_out, 32'h0000_0004);

    // Three wait cycles and a two-cycle stall
    do_instr(32'h2108_0001, 3, 2, 1'b0, 1'b0, 1'b0, 32'h0);
    check("stall_next_addr", imemAddr_out, 32'h0000_0008);

    // Directed next-PC table
    for (int i = 0; i < 5; i++) begin
      goto_pc(vecs[i].pre_pc);
      do_instr(vecs[i].instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
               vecs[i].br, vecs[i].z, vecs[i].j, vecs[i].off);
      check($sformatf("vec%0d_next_addr", i), imemAddr_out, vecs[i].exp_next);
    end

    // Randomized instructions against the PC model
    for (int n = 0; n < 40; n++) begin
      do_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom);
    end

    // Reset pulsed mid-FETCH with a data beat present
    goto_pc(32'h2000_0000);
    imemReady_in = 1'b1;
    imemData_in  = 32'hDEAD_BEEF;
    #2;
    reset_in = 1'b0;
    #1;
    check("midrst_state", 32'(state_out), 32'(IDLE));
    check("midrst_req", 32'(imemReq_out), 32'd0);
    check("midrst_addr", imemAddr_out, 32'h0);
    check("midrst_instr", instruction_out, 32'h0);
    check("midrst_pc_plus4", pcPlus4_out, 32'h4);
    step();
    check("midrst_held_state", 32'(state_out), 32'(IDLE));
    check("midrst_no_latch", instruction_out, 32'h0);
    reset_in     = 1'b1;
    imemReady_in = 1'b0;
    step();
    model_pc = 32'h0;
    check("resume_addr", imemAddr_out, 32'h0);
    do_instr(32'hAC09_0008, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("resume_next_addr", imemAddr_out, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
